fp_div_arbiter: RTL



---
 rtl/fp_div_pkg.sv | 22 ++
 rtl/fp_div_arbiter_rr_pick.sv | 27 ++
 rtl/fp_div_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/fp_div_pkg.sv
// Shared types and constants for the FpDiv arbiter: FSM states, round modes, canonical NaN.
package fp_div_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned RM_W   = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    GUARD = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } arb_state_e;

  localparam logic [RM_W-1:0] RM_RZ  = 2'b00;
  localparam logic [RM_W-1:0] RM_RUP = 2'b01;
  localparam logic [RM_W-1:0] RM_RNE = 2'b10;
  localparam logic [RM_W-1:0] RM_RDN = 2'b11;

  localparam logic [DATA_W-1:0] FP_QNAN = 32'h7FC00000;

endpackage

// File: rtl/fp_div_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot grant of the first set request at or above ptr_i.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PW'((32'(ptr_i) + k) % N);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_div_arbiter.sv
// Round-robin arbiter sharing one sequential FpDiv core among NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining FP_DIV_ARB_TIMEOUT_EN.
module fp_div_arbiter
  import fp_div_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  logic [NUM_REQ*2-1:0]  req_round,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic [31:0]           rsp_result,
  output logic                  rsp_err,
  output logic                  div_start,
  output logic [31:0]           div_a,
  output logic [31:0]           div_b,
  output logic [1:0]            div_round_mode,
  input  logic [31:0]           div_result,
  input  logic                  div_done
);

  localparam int unsigned PW = $clog2(NUM_REQ);

  arb_state_e            state_q;
  logic [PW-1:0]         ptr_q;
  logic [PW-1:0]         ptr_d;
  logic [PW-1:0]         grant_q;
  logic [DATA_W-1:0]     a_q;
  logic [DATA_W-1:0]     b_q;
  logic [RM_W-1:0]       rm_q;
  logic                  start_q;
  logic [DATA_W-1:0]     result_q;
  logic [NUM_REQ-1:0]    rsp_valid_q;

  logic [NUM_REQ-1:0]    gnt_oh;
  logic [PW-1:0]         gnt_idx;
  logic [DATA_W-1:0]     sel_a;
  logic [DATA_W-1:0]     sel_b;
  logic [RM_W-1:0]       sel_rm;
  logic                  accept;
  logic                  timeout_c;

  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt_oh)
  );

  // Grant index and operand select from the one-hot pick.
  always_comb begin
    gnt_idx = '0;
    sel_a   = '0;
    sel_b   = '0;
    sel_rm  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gnt_oh[k]) begin
        gnt_idx = PW'(k);
        sel_a   = req_a[k*32 +: 32];
        sel_b   = req_b[k*32 +: 32];
        sel_rm  = req_round[k*2 +: 2];
      end
    end
  end

  assign req_ready = (state_q == IDLE) ? gnt_oh : '0;
  assign accept    = |(req_valid & req_ready);
  assign ptr_d     = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + PW'(1);

`ifdef FP_DIV_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic          err_q;

  assign timeout_c = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Watchdog: cleared while in GUARD so it starts at zero on WAIT entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == GUARD) begin
        cnt_q <= '0;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (accept) begin
        err_q <= 1'b0;
      end else if ((state_q == WAIT) && !div_done && timeout_c) begin
        err_q <= 1'b1;
      end
    end
  end

  assign rsp_err = err_q;
`else
  assign timeout_c = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  // Main sequencer: accept, pulse start, guard stale done, wait, respond.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rm_q        <= '0;
      start_q     <= 1'b0;
      result_q    <= '0;
      rsp_valid_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= sel_a;
            b_q     <= sel_b;
            rm_q    <= sel_rm;
            grant_q <= gnt_idx;
            ptr_q   <= ptr_d;
            start_q <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          start_q <= 1'b0;
          state_q <= GUARD;
        end
        GUARD: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (div_done) begin
            result_q    <= div_result;
            rsp_valid_q <= NUM_REQ'(1) << grant_q;
            state_q     <= RESP;
          end else if (timeout_c) begin
            result_q    <= FP_QNAN;
            rsp_valid_q <= NUM_REQ'(1) << grant_q;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready[grant_q]) begin
            rsp_valid_q <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid      = rsp_valid_q;
  assign rsp_result     = result_q;
  assign div_start      = start_q;
  assign div_a          = a_q;
  assign div_b          = b_q;
  assign div_round_mode = rm_q;

endmodule
